// File: rtl/ram_responder.sv
// ram_responder: SIZE_RAM x 32-bit RAM answering level-held requests after LATENCY cycles.
// Define RAM_RESPONDER_WRITE_EN to enable writes; by default the memory is read-only (word i == i).
module ram_responder #(
    parameter int SIZE_RAM  = 4096,
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [31:0] address,
    input  logic        mode,
    output logic [31:0] out,
    output logic        response
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

    state_t               state_r;
    state_t               state_nx_s;
    logic [ADDR_BITS-1:0] idx_s;
    logic [ADDR_BITS-1:0] idx_r;
    logic                 mode_s;
    logic                 mode_r;
    logic [31:0]          data_s;
    logic [31:0]          data_r;
    logic                 tuple_vld_r;
    logic [7:0]           cnt_r;
    logic [7:0]           cnt_nx_s;
    logic [31:0]          out_r;
    logic [31:0]          out_nx_s;
    logic                 resp_r;
    logic                 resp_nx_s;
    logic [31:0]          rd_s;
    logic                 new_req_s;
    logic                 wr_s;

    assign idx_s = address[ADDR_BITS-1:0];

`ifdef RAM_RESPONDER_WRITE_EN
    logic [31:0] mem_s [SIZE_RAM];

    assign mode_s = mode;
    assign data_s = data;

    for (genvar i = 0; i < SIZE_RAM; i++) begin : g_word
        logic [31:0] word_r = 32'(i);

        // One storage word; outside the reset domain so contents survive rst.
        always_ff @(posedge clk) begin
            if (wr_s && (idx_r == ADDR_BITS'(i))) begin
                word_r <= data_r;
            end
        end

        assign mem_s[i] = word_r;
    end

    assign rd_s = mem_s[idx_r];
`else
    logic unused_s;

    // Read-only build: mode and data never reach the tuple, so word i always holds i.
    assign mode_s   = 1'b0;
    assign data_s   = 32'd0;
    assign rd_s     = 32'(idx_r);
    assign unused_s = ^{mode, data, wr_s};
`endif

    assign new_req_s = !tuple_vld_r || (idx_s != idx_r) || (mode_s != mode_r) || (data_s != data_r);

    // Next-state: a new tuple always restarts; otherwise BUSY counts up to completion.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        out_nx_s   = out_r;
        resp_nx_s  = resp_r;
        wr_s       = 1'b0;
        if (new_req_s) begin
            state_nx_s = BUSY;
            cnt_nx_s   = 8'd0;
            resp_nx_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx_s = IDLE;
                end
                BUSY: begin
                    if (cnt_r == LAST_CNT) begin
                        state_nx_s = IDLE;
                        resp_nx_s  = 1'b0;
                        wr_s       = mode_r;
                        out_nx_s   = mode_r ? data_r : rd_s;
                    end else begin
                        cnt_nx_s = cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    resp_nx_s  = 1'b0;
                end
            endcase
        end
    end

    // Control state, latched request tuple and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            tuple_vld_r <= 1'b0;
            idx_r       <= {ADDR_BITS{1'b0}};
            mode_r      <= 1'b0;
            data_r      <= 32'd0;
            cnt_r       <= 8'd0;
            out_r       <= 32'd0;
            resp_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            out_r   <= out_nx_s;
            resp_r  <= resp_nx_s;
            if (new_req_s) begin
                tuple_vld_r <= 1'b1;
                idx_r       <= idx_s;
                mode_r      <= mode_s;
                data_r      <= data_s;
            end else begin
                tuple_vld_r <= tuple_vld_r;
            end
        end
    end

    assign out      = out_r;
    assign response = resp_r;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: stimulus pushes expected completions, a monitor checks them.
module tb_ram_responder;

    localparam int SIZE_RAM  = 4096;
    localparam int ADDR_BITS = 12;
    localparam int LAT       = 4;
    localparam int N_RAND    = 60;

    typedef struct {
        logic [31:0] out;
        int          busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [31:0] address;
    logic        mode;
    logic [31:0] out;
    logic        response;

    exp_t                 exp_q [$];
    logic [31:0]          model_mem [SIZE_RAM];
    logic                 last_valid;
    logic [ADDR_BITS-1:0] last_ix;
    logic                 last_m;
    logic [31:0]          last_d;
    logic [31:0]          last_out;
    int                   acc;
    int                   n_checks = 0;
    int                   n_fail   = 0;

    ram_responder #(
        .SIZE_RAM (SIZE_RAM),
        .ADDR_BITS(ADDR_BITS),
        .LATENCY  (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .address (address),
        .mode    (mode),
        .out     (out),
        .response(response)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [ADDR_BITS-1:0] ix_of(input logic [31:0] a);
        return a[ADDR_BITS-1:0];
    endfunction

    // Tuple as the block sees it: without writes, mode and data do not matter.
    function automatic logic same_as_last(input logic [31:0] a, input logic m, input logic [31:0] d);
        logic        em;
        logic [31:0] ed;
`ifdef RAM_RESPONDER_WRITE_EN
        em = m;
        ed = d;
`else
        em = 1'b0;
        ed = 32'd0;
`endif
        return last_valid && (ix_of(a) == last_ix) && (em == last_m) && (ed == last_d);
    endfunction

    // Apply a tuple just after a rising edge and hold it for h rising edges.
    // It completes only if it is still present on the LAT-th edge after detection (h > LAT).
    task automatic do_op(input logic [31:0] a, input logic m, input logic [31:0] d, input int h);
        logic [ADDR_BITS-1:0] ix;
        logic                 em;
        logic [31:0]          ed;
        logic                 idle_hold;
        exp_t                 e;
        ix = ix_of(a);
`ifdef RAM_RESPONDER_WRITE_EN
        em = m;
        ed = d;
`else
        em = 1'b0;
        ed = 32'd0;
`endif
        idle_hold = same_as_last(a, m, d);
        if (!idle_hold) begin
            last_valid = 1'b1;
            last_ix    = ix;
            last_m     = em;
            last_d     = ed;
            if (h > LAT) begin
                e.out  = em ? ed : model_mem[ix];
                e.busy = acc + LAT;
                exp_q.push_back(e);
                if (em) model_mem[ix] = ed;
                last_out = e.out;
                acc      = 0;
            end else begin
                acc = acc + h;
            end
        end
        address = a;
        mode    = m;
        data    = d;
        repeat (h) begin
            @(negedge clk);
            if (idle_hold) begin
                check32("no_req_response", {31'd0, response}, 32'd0);
                check32("no_req_out", out, last_out);
            end
            @(posedge clk);
        end
        #1;
    endtask

    // Monitor: on every falling response, pop the oldest expectation and compare.
    initial begin
        int   run;
        logic prev;
        exp_t e;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run  = 0;
                prev = 1'b0;
            end else begin
                if (response) begin
                    run++;
                end else if (prev) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_completion: out %h with nothing pending", out);
                    end else begin
                        e = exp_q.pop_front();
                        check32("completion_out", out, e.out);
                        check32("busy_cycles", 32'(run), 32'(e.busy));
                    end
                    run = 0;
                end
                prev = response;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        m;
        int          h;

        for (int i = 0; i < SIZE_RAM; i++) model_mem[i] = 32'(i);
        last_valid = 1'b0;
        last_ix    = {ADDR_BITS{1'b0}};
        last_m     = 1'b0;
        last_d     = 32'd0;
        last_out   = 32'd0;
        acc        = 0;

        rst     = 1'b1;
        address = 32'd5;
        mode    = 1'b0;
        data    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_out", out, 32'd0);
        check32("reset_response", {31'd0, response}, 32'd0);
        rst = 1'b0;

        // Plain read, write-then-read, abort, address wrap.
        do_op(32'd5, 1'b0, 32'd0, LAT + 1);
        do_op(32'd7, 1'b1, 32'hDEADBEEF, LAT + 1);
        do_op(32'd7, 1'b0, 32'hDEADBEEF, LAT + 1);
        do_op(32'd9, 1'b0, 32'd0, 2);
        do_op(32'd10, 1'b0, 32'd0, LAT + 1);
        do_op(32'd3, 1'b0, 32'd0, LAT + 1);
        do_op(32'd4099, 1'b0, 32'd0, LAT + 2);

        // Reset in the middle of a write abandons it.
        do_op(32'd20, 1'b1, 32'h55, 2);
        #2 rst = 1'b1;
        #1;
        check32("midreset_out", out, 32'd0);
        check32("midreset_response", {31'd0, response}, 32'd0);
        last_valid = 1'b0;
        acc        = 0;
        last_out   = 32'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        do_op(32'd20, 1'b0, 32'd0, LAT + 1);
        do_op(32'd30, 1'b1, 32'hFF, LAT + 1);
        do_op(32'd30, 1'b0, 32'hFF, LAT + 1);

        for (int i = 0; i < N_RAND; i++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = (32'($urandom_range(0, 7)) << ADDR_BITS) | 32'($urandom_range(0, 5));
            m = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 2));
            if (acc != 0 && same_as_last(a, m, d)) a = a ^ 32'd1;
            if (i < N_RAND - 1 && $urandom_range(0, 3) == 0) h = $urandom_range(1, LAT);
            else h = $urandom_range(LAT + 1, LAT + 3);
            do_op(a, m, d, h);
        end

        repeat (LAT + 4) @(posedge clk);
        #1;
        check32("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
